// File: rtl/mux_pkg.sv
// Shared state encoding for the two-requester arbiter.
package mux_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] OWN0 = 2'b01;
  localparam logic [1:0] OWN1 = 2'b10;

  localparam int unsigned HOLD_W = 8;

  // Ownership state for a given side (0 -> OWN0, 1 -> OWN1).
  function automatic logic [1:0] own_state(input logic side);
    return side ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/mux2.sv
// Single-bit 2:1 multiplexer.
module mux2 (
  input  logic select,
  input  logic in0,
  input  logic in1,
  output logic out
);

  assign out = select ? in1 : in0;

endmodule

// File: rtl/mux2_arbiter.sv
// Two-requester round-robin arbiter driving a registered 2:1 data mux.
// Define MUX2_ARB_TIMEOUT_EN to compile in hold-limit preemption after MAX_HOLD grant cycles.
module mux2_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             select,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("mux2_arbiter: MAX_HOLD must be within 2..255");
  end

  logic [1:0] state_q, state_d;
  logic       select_q, select_d;
  logic       last_q, last_d;
  logic       entry;

`ifdef MUX2_ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HoldMax = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              hold_sat;

  assign hold_sat = (hold_q == HoldMax);
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          state_d = own_state(~last_q);
        end else if (req0) begin
          state_d = OWN0;
        end else if (req1) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (!req0) begin
          state_d = req1 ? OWN1 : IDLE;
        end
`ifdef MUX2_ARB_TIMEOUT_EN
        else if (req1 && hold_sat) begin
          state_d = OWN1;
        end
`endif
      end
      OWN1: begin
        if (!req1) begin
          state_d = req0 ? OWN0 : IDLE;
        end
`ifdef MUX2_ARB_TIMEOUT_EN
        else if (req0 && hold_sat) begin
          state_d = OWN0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // A new owner (from IDLE or a direct handover) latches select and last_served.
  assign entry    = (state_d != state_q) && (state_d != IDLE);
  assign select_d = entry ? (state_d == OWN1) : select_q;
  assign last_d   = entry ? (state_d == OWN1) : last_q;

`ifdef MUX2_ARB_TIMEOUT_EN
  always_comb begin
    hold_d = hold_q;
    if (entry) begin
      hold_d = '0;
    end else if (state_q != IDLE && !hold_sat) begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`endif

  // last_served resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      select_q <= 1'b0;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      select_q <= select_d;
      last_q   <= last_d;
    end
  end

  assign gnt0      = (state_q == OWN0);
  assign gnt1      = (state_q == OWN1);
  assign out_valid = gnt0 | gnt1;
  assign select    = select_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux2 u_mux2 (
      .select (select_q),
      .in0    (in0[i]),
      .in1    (in1[i]),
      .out    (out[i])
    );
  end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Scoreboard bench for mux2_arbiter: directed scenarios followed by random traffic.
module tb_mux2_arbiter;

  localparam int unsigned W  = 4;
  localparam int unsigned MH = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req0 = 1'b0;
  logic         req1 = 1'b0;
  logic [W-1:0] in0 = '0;
  logic [W-1:0] in1 = '0;
  logic         gnt0, gnt1, select, out_valid;
  logic [W-1:0] out;

  mux2_arbiter #(
    .WIDTH    (W),
    .MAX_HOLD (MH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .in0       (in0),
    .in1       (in1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .select    (select),
    .out       (out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic g0;
    logic g1;
    logic sel;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: owner is -1 (nobody), 0 or 1; tenure counts granted cycles so far.
  int m_owner = -1;
  int m_last  = 1;
  int m_sel   = 0;
  int m_ten   = 0;

  int n_pass  = 0;
  int n_total = 0;

  task automatic model_step(input logic r0, input logic r1, input logic rst);
    exp_t e;
    int   pick;
    bit   mine, theirs;
    if (rst) begin
      m_owner = -1;
      m_last  = 1;
      m_sel   = 0;
      m_ten   = 0;
    end else begin
      pick = m_owner;
      if (m_owner < 0) begin
        if (r0 && r1) pick = 1 - m_last;
        else if (r0)  pick = 0;
        else if (r1)  pick = 1;
      end else begin
        mine   = (m_owner == 0) ? r0 : r1;
        theirs = (m_owner == 0) ? r1 : r0;
        if (!mine) pick = theirs ? 1 - m_owner : -1;
`ifdef MUX2_ARB_TIMEOUT_EN
        else if (theirs && m_ten >= int'(MH)) pick = 1 - m_owner;
`endif
      end
      if (pick < 0) begin
        m_owner = -1;
      end else if (pick == m_owner) begin
        m_ten++;
      end else begin
        m_owner = pick;
        m_ten   = 1;
        m_last  = pick;
        m_sel   = pick;
      end
    end
    e.g0  = (m_owner == 0);
    e.g1  = (m_owner == 1);
    e.sel = (m_sel == 1);
    sb_q.push_back(e);
  endtask

  task automatic step(input logic r0, input logic r1, input logic rst);
    @(negedge clk);
    req0  = r0;
    req1  = r1;
    in0   = W'($urandom);
    in1   = W'($urandom);
    reset = rst;
    model_step(r0, r1, rst);
  endtask

  // Asserts reset mid-cycle and checks the outputs clear without waiting for a clock edge.
  task automatic reset_now();
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_total++;
    if ({gnt0, gnt1, select, out_valid} == 4'b0000) begin
      n_pass++;
    end else begin
      $display("FAIL async_reset t=%0t got gnt0=%0b gnt1=%0b select=%0b out_valid=%0b want all 0",
               $time, gnt0, gnt1, select, out_valid);
    end
    model_step(req0, req1, 1'b1);
  endtask

  // Monitor: one scoreboard entry is consumed per clock edge.
  initial begin
    forever begin
      exp_t         e;
      logic [W-1:0] eo;
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e  = sb_q.pop_front();
        eo = e.sel ? in1 : in0;
        n_total++;
        if ({gnt0, gnt1, select, out_valid, out} == {e.g0, e.g1, e.sel, e.g0 | e.g1, eo}) begin
          n_pass++;
        end else begin
          $display("FAIL cycle_check t=%0t got g0=%0b g1=%0b sel=%0b v=%0b out=%h want g0=%0b g1=%0b sel=%0b v=%0b out=%h",
                   $time, gnt0, gnt1, select, out_valid, out, e.g0, e.g1, e.sel, e.g0 | e.g1, eo);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t simulation did not finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic r0, r1;
    // Reset state, then a single requester for four cycles.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0);

    // Tie right after reset, then handover without an idle bubble.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Round-robin on back-to-back ties.
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Long hold with a waiting competitor.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Reset while requester 1 owns, then release with no requests.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    reset_now();
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);

    // Random level requests with occasional resets.
    r0 = 1'b0;
    r1 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) r0 = ~r0;
      if ($urandom_range(3) == 0) r1 = ~r1;
      if ($urandom_range(250) == 0) begin
        reset_now();
        step(r0, r1, 1'b1);
      end else begin
        step(r0, r1, 1'b0);
      end
    end

    @(posedge clk);
    #2;
    n_total++;
    if (sb_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain got %0d pending entries want 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
